// File: rtl/lmsm_pkg.sv
// rtl/lmsm_pkg.sv - shared widths, mode constants and state type for the LM/SM sequencer
package lmsm_pkg;
   localparam int DATA_W = 16;
   localparam int NREG   = 8;
   localparam int SEL_W  = 3;

   localparam logic MODE_LM = 1'b0;
   localparam logic MODE_SM = 1'b1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      XFER = 2'd1,
      DONE = 2'd2
   } state_t;
endpackage

// File: rtl/lmsm_sequencer_if.sv
// rtl/lmsm_sequencer_if.sv - request, register-file and memory signals of the LM/SM sequencer
interface lmsm_sequencer_if;
   import lmsm_pkg::*;

   logic              start;
   logic              mode;
   logic [NREG-1:0]   mask;
   logic [DATA_W-1:0] base_addr;
   logic [DATA_W-1:0] rf_rdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_ack;
   logic [SEL_W-1:0]  reg_sel;
   logic [DATA_W-1:0] mem_addr;
   logic              mem_re;
   logic              mem_we;
   logic [DATA_W-1:0] mem_wdata;
   logic              rf_we;
   logic [SEL_W-1:0]  rf_waddr;
   logic [DATA_W-1:0] rf_wdata;
   logic              busy;
   logic              done;

   modport master (
      input  start, mode, mask, base_addr, rf_rdata, mem_rdata, mem_ack,
      output reg_sel, mem_addr, mem_re, mem_we, mem_wdata,
             rf_we, rf_waddr, rf_wdata, busy, done
   );

   modport slave (
      output start, mode, mask, base_addr, rf_rdata, mem_rdata, mem_ack,
      input  reg_sel, mem_addr, mem_re, mem_we, mem_wdata,
             rf_we, rf_waddr, rf_wdata, busy, done
   );
endinterface

// File: rtl/lowest_set_enc.sv
// rtl/lowest_set_enc.sv - index of the lowest set bit of the register mask, plus valid
module lowest_set_enc
   import lmsm_pkg::*;
(
   input  logic [NREG-1:0]  vec,
   output logic [SEL_W-1:0] idx,
   output logic             valid
);
   // Scan high to low so the lowest set bit is the last one written.
   always_comb begin
      idx   = '0;
      valid = 1'b0;
      for (int i = NREG - 1; i >= 0; i--) begin
         if (vec[i]) begin
            idx   = SEL_W'(i);
            valid = 1'b1;
         end
      end
   end
endmodule

// File: rtl/lmsm_sequencer.sv
// rtl/lmsm_sequencer.sv - walks an LM/SM register mask, one memory transfer per set bit
module lmsm_sequencer
   import lmsm_pkg::*;
#(
   parameter logic [DATA_W-1:0] ADDR_INC = 1
) (
   input logic                 clk,
   input logic                 rst,
   lmsm_sequencer_if.master    bus
);
   state_t            state, state_nxt;
   logic              mode_q, mode_nxt;
   logic [NREG-1:0]   pend_q, pend_nxt;
   logic [NREG-1:0]   pend_rest;
   logic [DATA_W-1:0] addr_q, addr_nxt;
   logic [SEL_W-1:0]  cur_idx;
   logic              cur_valid;
   logic              xfer;

   lowest_set_enc u_enc (
      .vec   (pend_q),
      .idx   (cur_idx),
      .valid (cur_valid)
   );

   // Pending mask with its lowest set bit cleared.
   assign pend_rest = pend_q & (pend_q - NREG'(1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         mode_q <= MODE_LM;
         pend_q <= '0;
         addr_q <= '0;
      end else begin
         state  <= state_nxt;
         mode_q <= mode_nxt;
         pend_q <= pend_nxt;
         addr_q <= addr_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      mode_nxt  = mode_q;
      pend_nxt  = pend_q;
      addr_nxt  = addr_q;
      case (state)
         IDLE: begin
            if (bus.start) begin
               mode_nxt  = bus.mode;
               pend_nxt  = bus.mask;
               addr_nxt  = bus.base_addr;
               state_nxt = (bus.mask == '0) ? DONE : XFER;
            end
         end
         XFER: begin
            if (bus.mem_ack) begin
               pend_nxt  = pend_rest;
               addr_nxt  = addr_q + ADDR_INC;
               state_nxt = (pend_rest == '0) ? DONE : XFER;
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign xfer          = (state == XFER) && cur_valid;
   assign bus.reg_sel   = cur_idx;
   assign bus.rf_waddr  = cur_idx;
   assign bus.mem_addr  = addr_q;
   assign bus.mem_re    = xfer && (mode_q == MODE_LM);
   assign bus.mem_we    = xfer && (mode_q == MODE_SM);
   assign bus.rf_we     = bus.mem_re && bus.mem_ack;
   assign bus.mem_wdata = bus.rf_rdata;
   assign bus.rf_wdata  = bus.mem_rdata;
   assign bus.busy      = (state != IDLE);
   assign bus.done      = (state == DONE);
endmodule

// File: tb/tb_lmsm_sequencer.sv
// tb/tb_lmsm_sequencer.sv - self-checking bench for lmsm_sequencer
module tb_lmsm_sequencer;
   import lmsm_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   lmsm_sequencer_if bus ();

   lmsm_sequencer dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic        mode;
      logic [7:0]  mask;
      logic [15:0] base;
      int          delay;       // fixed ack wait per transfer, -1 = random 0..3
      int          restart_at;  // cycle of an extra start while busy, -1 = none
      int          exp_done;    // expected done cycle, -1 = not checked
   } vec_t;

   vec_t vecs[7];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic chk_quiet(input string tag);
      chk({tag, " busy"},   32'(bus.busy),   32'd0);
      chk({tag, " done"},   32'(bus.done),   32'd0);
      chk({tag, " mem_re"}, 32'(bus.mem_re), 32'd0);
      chk({tag, " mem_we"}, 32'(bus.mem_we), 32'd0);
      chk({tag, " rf_we"},  32'(bus.rf_we),  32'd0);
   endtask

   task automatic run_seq(input string tag, input logic md, input logic [7:0] mk,
                          input logic [15:0] bs, input int delay, input int restart_at,
                          input int exp_done);
      int          exp_idx[$];
      logic [15:0] exp_addr[$];
      int          k = 0;
      int          w;
      int          done_cyc = -1;
      logic        ack;
      logic        want_re;
      logic        want_rfwe;

      // Reference: ascending register index, consecutive 16-bit wrapping addresses.
      for (int i = 0; i < NREG; i++) begin
         if (mk[i]) begin
            exp_idx.push_back(i);
            exp_addr.push_back(bs + 16'(k));
            k++;
         end
      end
      w = (delay < 0) ? int'($urandom_range(0, 3)) : delay;

      bus.start     = 1'b1;
      bus.mode      = md;
      bus.mask      = mk;
      bus.base_addr = bs;
      bus.mem_ack   = 1'($urandom_range(0, 1));
      bus.rf_rdata  = 16'($urandom);
      bus.mem_rdata = 16'($urandom);
      @(negedge clk);
      chk({tag, " c0 busy"}, 32'(bus.busy), 32'd0);
      @(posedge clk); #1;
      bus.mode      = !md;
      bus.mask      = 8'($urandom);
      bus.base_addr = 16'($urandom);

      for (int cyc = 1; cyc <= 80 && done_cyc < 0; cyc++) begin
         if (cyc == restart_at) begin
            bus.start = 1'b1;
            bus.mask  = 8'h01;
         end else begin
            bus.start = 1'b0;
         end
         ack = (exp_idx.size() > 0) ? (w == 0) : 1'($urandom_range(0, 1));
         bus.mem_ack   = ack;
         bus.rf_rdata  = 16'($urandom);
         bus.mem_rdata = 16'($urandom);
         @(negedge clk);
         if (exp_idx.size() > 0) begin
            want_re   = !md;
            want_rfwe = (!md) && ack;
            chk({tag, " busy"},      32'(bus.busy),      32'd1);
            chk({tag, " done early"},32'(bus.done),      32'd0);
            chk({tag, " mem_re"},    32'(bus.mem_re),    32'(want_re));
            chk({tag, " mem_we"},    32'(bus.mem_we),    32'(md));
            chk({tag, " reg_sel"},   32'(bus.reg_sel),   32'(exp_idx[0]));
            chk({tag, " rf_waddr"},  32'(bus.rf_waddr),  32'(exp_idx[0]));
            chk({tag, " mem_addr"},  32'(bus.mem_addr),  32'(exp_addr[0]));
            chk({tag, " rf_we"},     32'(bus.rf_we),     32'(want_rfwe));
            chk({tag, " mem_wdata"}, 32'(bus.mem_wdata), 32'(bus.rf_rdata));
            chk({tag, " rf_wdata"},  32'(bus.rf_wdata),  32'(bus.mem_rdata));
            if (ack) begin
               void'(exp_idx.pop_front());
               void'(exp_addr.pop_front());
               w = (delay < 0) ? int'($urandom_range(0, 3)) : delay;
            end else begin
               w--;
            end
         end else begin
            chk({tag, " done"},        32'(bus.done),   32'd1);
            chk({tag, " busy at done"},32'(bus.busy),   32'd1);
            chk({tag, " re at done"},  32'(bus.mem_re), 32'd0);
            chk({tag, " we at done"},  32'(bus.mem_we), 32'd0);
            chk({tag, " rfwe at done"},32'(bus.rf_we),  32'd0);
            done_cyc = cyc;
         end
         @(posedge clk); #1;
      end
      bus.start = 1'b0;

      if (done_cyc < 0) begin
         total++;
         bad++;
         $display("FAIL %s timeout: no done within 80 cycles, %0d transfers left", tag, exp_idx.size());
      end else if (exp_done >= 0) begin
         chk({tag, " done cycle"}, 32'(done_cyc), 32'(exp_done));
      end

      bus.mem_ack = 1'b1;
      @(negedge clk);
      chk_quiet({tag, " idle"});
      @(posedge clk); #1;
      bus.mem_ack = 1'b0;
   endtask

   initial begin
      vecs[0] = '{1'b1, 8'b1000_0101, 16'h0100, 0, -1, 4};
      vecs[1] = '{1'b0, 8'b0000_0011, 16'h0020, 2, -1, 7};
      vecs[2] = '{1'b0, 8'h00,        16'h1234, 0, -1, 1};
      vecs[3] = '{1'b1, 8'hFF,        16'hFFFE, 0, -1, 9};
      vecs[4] = '{1'b0, 8'hFF,        16'hFFFE, 1, -1, 17};
      vecs[5] = '{1'b1, 8'b0110_1000, 16'h0007, 0,  2, 4};
      vecs[6] = '{1'b0, 8'h80,        16'hAAAA, 3, -1, 5};

      rst           = 1'b1;
      bus.start     = 1'b0;
      bus.mode      = 1'b0;
      bus.mask      = '0;
      bus.base_addr = '0;
      bus.rf_rdata  = '0;
      bus.mem_rdata = '0;
      bus.mem_ack   = 1'b0;
      @(negedge clk);
      chk_quiet("reset");
      chk("reset reg_sel",  32'(bus.reg_sel),  32'd0);
      chk("reset mem_addr", 32'(bus.mem_addr), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;

      for (int v = 0; v < 7; v++) begin
         run_seq($sformatf("vec%0d", v), vecs[v].mode, vecs[v].mask, vecs[v].base,
                 vecs[v].delay, vecs[v].restart_at, vecs[v].exp_done);
      end

      // Reset during the third of five SM transfers.
      bus.start     = 1'b1;
      bus.mode      = 1'b1;
      bus.mask      = 8'h1F;
      bus.base_addr = 16'h0040;
      bus.mem_ack   = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      @(negedge clk);
      chk("rst pre mem_we",   32'(bus.mem_we),   32'd1);
      chk("rst pre reg_sel",  32'(bus.reg_sel),  32'd2);
      chk("rst pre mem_addr", 32'(bus.mem_addr), 32'h0042);
      #2 rst = 1'b1;
      #1;
      chk_quiet("rst async");
      chk("rst async reg_sel",  32'(bus.reg_sel),  32'd0);
      chk("rst async mem_addr", 32'(bus.mem_addr), 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
      chk_quiet("rst held");
      @(posedge clk); #1;
      rst = 1'b0;
      bus.mem_ack = 1'b0;
      @(posedge clk); #1;
      run_seq("post-rst", 1'b1, 8'h1F, 16'h0040, 0, -1, 6);

      for (int r = 0; r < 30; r++) begin
         logic        md;
         logic [7:0]  mk;
         logic [15:0] bs;
         int          dl;
         int          rs;
         int          ed;
         md = 1'($urandom_range(0, 1));
         mk = 8'($urandom_range(0, 255));
         bs = 16'($urandom);
         dl = ($urandom_range(0, 1) == 0) ? 0 : -1;
         rs = ($countones(mk) >= 2) ? int'($urandom_range(1, $countones(mk))) : -1;
         ed = (dl == 0) ? ($countones(mk) + 1) : -1;
         run_seq($sformatf("rnd%0d", r), md, mk, bs, dl, rs, ed);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
